// File: rtl/muldiv_unit_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE, MD_BUSY, MD_DONE
  } muldiv_state_t;

  function automatic logic is_div(muldiv_op_t op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic a_signed(muldiv_op_t op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic b_signed(muldiv_op_t op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add (multiply) or restoring shift-subtract
// (divide) on the {acc, opr} register pair against a fixed operand.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] opr_i,
  input  logic [XLEN-1:0] operand_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] opr_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shl;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, acc_i} + (opr_i[0] ? {1'b0, operand_i} : '0);
    shl  = {acc_i, opr_i[XLEN-1]};
    diff = shl - {1'b0, operand_i};
    acc_o = '0;
    opr_o = '0;
    if (div_i) begin
      // Partial remainder stays below the divisor, so diff's top bit is a clean borrow flag.
      if (!diff[XLEN]) begin
        acc_o = diff[XLEN-1:0];
        opr_o = {opr_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = shl[XLEN-1:0];
        opr_o = {opr_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = sum[XLEN:1];
      opr_o = {sum[0], opr_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on magnitudes, sign fixup on
// the final iteration, RISC-V divide-by-zero and overflow results without traps.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  muldiv_op_t      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q;
  muldiv_op_t      op_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, opr_q, opnd_q, result_q;
  logic            neg_q, rneg_q;

  logic            accept, a_neg, b_neg, b_zero, ovf, early, op_div;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [XLEN-1:0] step_acc, step_opr, fix_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign in_ready   = (state_q == MD_IDLE) && !flush;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == MD_DONE);
  assign busy       = (state_q != MD_IDLE);
  assign out_result = result_q;
  assign op_div     = is_div(op_q);

  always_comb begin
    a_neg  = a_signed(in_op) && in_a[XLEN-1];
    b_neg  = b_signed(in_op) && in_b[XLEN-1];
    a_mag  = a_neg ? -in_a : in_a;
    b_mag  = b_neg ? -in_b : in_b;
    b_zero = (in_b == '0);
    ovf    = ((in_op == MD_DIV) || (in_op == MD_REM)) && (in_a == MIN_INT) && (in_b == '1);
    early  = EARLY_OUT && is_div(in_op) && (b_zero || ovf);
    special_res = '0;
    if (b_zero)
      special_res = ((in_op == MD_DIV) || (in_op == MD_DIVU)) ? '1 : in_a;
    else if (in_op == MD_DIV)
      special_res = MIN_INT;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_i     (op_div),
    .acc_i     (acc_q),
    .opr_i     (opr_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc),
    .opr_o     (step_opr)
  );

  // Sign fixup is folded into the last iteration so DONE carries the final result.
  always_comb begin
    prod     = {step_acc, step_opr};
    prod_fix = neg_q ? -prod : prod;
    fix_res  = '0;
    case (op_q)
      MD_MUL:                       fix_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res = neg_q ? -step_opr : step_opr;
      default:                      fix_res = rneg_q ? -step_acc : step_acc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      opr_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            op_q   <= in_op;
            cnt_q  <= '0;
            acc_q  <= '0;
            opr_q  <= a_mag;
            opnd_q <= b_mag;
            // A zero divisor must leave the all-ones quotient unnegated.
            neg_q  <= (a_neg ^ b_neg) && !(is_div(in_op) && b_zero);
            rneg_q <= a_neg;
            if (early) begin
              result_q <= special_res;
              state_q  <= MD_DONE;
            end else begin
              state_q  <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          if (flush) begin
            state_q <= MD_IDLE;
          end else begin
            acc_q <= step_acc;
            opr_q <= step_opr;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN-1)) begin
              result_q <= fix_res;
              state_q  <= MD_DONE;
            end
          end
        end
        MD_DONE: begin
          if (flush || out_ready) state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

`ifdef __DUMP_STATE__
  task automatic dump_state();
    $display("muldiv op=%s acc=%h opr=%h opnd=%h state=%s cnt=%0d result=%h",
             op_q.name(), acc_q, opr_q, opnd_q, state_q.name(), cnt_q, result_q);
  endtask
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32, EARLY_OUT=1) with hand-computed results.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  muldiv_op_t  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic        in_ready, out_valid, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, wait for the result and pop it.
  task automatic run_op(input string tag, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int guard;
    int lat;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_irdy"}, 32'(in_ready), 32'd1);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = MD_MULHU; in_a = 32'hDEADBEEF; in_b = 32'h0BADF00D;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, out_result, exp);
    if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int guard;
    int seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = MD_MUL; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irdy", 32'(in_ready), 32'd1);
    check("rst_ovld", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res",  out_result, 32'd0);
    @(negedge clk); reset = 1'b0;

    run_op("mul",    MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulhu",  MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh",   MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhsu", MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("mul0",   MD_MUL,    32'd0,        32'd12345,    32'd0,        33);
    run_op("div",    MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   MD_DIVU,   32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   MD_REMU,   32'd100,      32'd7,        32'd2,        33);
    run_op("divn",   MD_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    run_op("remn",   MD_REM,    32'd100,      32'hFFFFFFF9, 32'd2,        33);
    run_op("divu0",  MD_DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 1);
    run_op("rem0",   MD_REM,    32'h1234,     32'd0,        32'h1234,     1);
    run_op("divneg0", MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1);
    run_op("remneg0", MD_REM,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
    run_op("divovf", MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Result held under back-pressure; a pending request waits for IDLE.
    @(negedge clk);
    in_op = MD_MUL; in_a = 32'd3; in_b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    in_op = MD_DIVU; in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_res",  out_result, 32'd15);
      check("hold_vld",  32'(out_valid), 32'd1);
      check("hold_irdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("nobyp_busy", 32'(busy), 32'd0);
    check("nobyp_irdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("next_busy", 32'(busy), 32'd1);
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("next_res", out_result, 32'd14);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Flush at count 10, then flush against a request in IDLE.
    @(negedge clk);
    in_op = MD_DIVU; in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_vld",  32'(out_valid), 32'd0);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = MD_MUL; in_a = 32'd3; in_b = 32'd3;
    #1;
    check("fl_irdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("fl_noacc", 32'(busy), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("fl_noval", 32'(seen), 32'd0);

    // Asynchronous reset between edges while busy.
    @(negedge clk);
    in_op = MD_MULHU; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_irdy", 32'(in_ready), 32'd1);
    check("arst_ovld", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_res",  out_result, 32'd0);
    @(negedge clk); reset = 1'b0;
    run_op("post_rst", MD_REMU, 32'd100, 32'd7, 32'd2, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
